// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX among NUM_REQ byte streams.
// Optional lock watchdog: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        win_idx, owner_inc;
  logic [NUM_REQ-1:0]   grant_d;
  logic                 win_found;
  logic                 owner_valid, owner_last;
  logic [7:0]           owner_data;
  logic                 slot_free, accept;
  logic                 timeout, release_lock;

  assign owner_valid = req_valid_i[owner_q];
  assign owner_last  = req_last_i[owner_q];
  assign owner_data  = req_data_i[owner_q*8 +: 8];
  assign owner_inc   = (owner_q == IW'(NUM_REQ-1)) ? '0
                     : owner_q + IW'(1);

  // out stage can take a byte when empty or draining this cycle
  assign slot_free = ~tx_valid_o | tx_ready_i;
  assign accept    = (state_q == LOCKED) & owner_valid & slot_free;

  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!win_found && req_valid_i[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] timer_q;

  assign timeout = (state_q == LOCKED)
                 & (timer_q == 16'(LOCK_TIMEOUT-1));

  // only owner silence counts; TX backpressure never ages the lock
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      timer_q <= '0;
    end else if (state_q != LOCKED || accept) begin
      timer_q <= '0;
    end else if (!owner_valid) begin
      timer_q <= timer_q + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign release_lock = (accept & owner_last) | timeout;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      grant_o    <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_o  <= grant_d;
      if (accept) begin
        tx_valid_o <= 1'b1;
        tx_data_o  <= owner_data;
      end else if (tx_ready_i) begin
        tx_valid_o <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_o;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOCKED;
          owner_d = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
        end
      end
      LOCKED: begin
        if (release_lock) begin
          state_d  = IDLE;
          rr_ptr_d = owner_inc;
          grant_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == LOCKED) begin
      req_ready_o[owner_q] = slot_free;
    end
    busy_o = (state_q == LOCKED) | tx_valid_o;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=2, LOCK_TIMEOUT=8).
// Requester queues are advanced on observed valid&ready handshakes.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic [1:0]  req_valid_i;
  logic [15:0] req_data_i;
  logic [1:0]  req_last_i;
  logic [1:0]  req_ready_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic [1:0]  grant_o;
  logic        busy_o;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] rx[$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (2),
    .LOCK_TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .reset_n_i  (reset_n_i),
    .req_valid_i(req_valid_i),
    .req_data_i (req_data_i),
    .req_last_i (req_last_i),
    .req_ready_o(req_ready_o),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_i (tx_ready_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_valid_i = {q1.size() != 0, q0.size() != 0};
    req_data_i  = '0;
    req_last_i  = '0;
    if (q0.size() != 0) begin
      req_data_i[7:0] = q0[0][7:0];
      req_last_i[0]   = q0[0][8];
    end
    if (q1.size() != 0) begin
      req_data_i[15:8] = q1[0][7:0];
      req_last_i[1]    = q1[0][8];
    end
  endtask

  task automatic tick();
    logic [1:0] acc;
    #1;
    acc = req_valid_i & req_ready_o;
    if (tx_valid_o && tx_ready_i) rx.push_back(tx_data_o);
    @(posedge clk);
    #1;
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    drive();
    tx_ready_i = 1'b1;
    reset_n_i  = 1'b0;
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();
    rx.delete();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c;
    c = 0;
    while (rx.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("rx_count", rx.size(), n);
  endtask

  task automatic chk_rx(input string tag, input int i,
                        input logic [7:0] exp);
    if (i < rx.size()) chk(tag, rx[i], exp);
    else chk(tag, 32'hdead, exp);
  endtask

  initial begin
    logic [7:0] e3a [6];
    logic [7:0] e3b [7];
    logic [7:0] e4  [3];
    logic [7:0] e5  [4];
    e3a = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
    e3b = '{8'hE1, 8'hD1, 8'hD2, 8'hD3, 8'hC1, 8'hC2, 8'hC3};
    e4  = '{8'h61, 8'h62, 8'h63};
    e5  = '{8'h55, 8'h71, 8'h72, 8'h73};

    // reset with both requesters asserting valid
    reset_n_i   = 1'b0;
    tx_ready_i  = 1'b1;
    req_valid_i = 2'b11;
    req_data_i  = 16'h5a5a;
    req_last_i  = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid_o, 0);
    chk("rst_tx_data", tx_data_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_busy", busy_o, 0);

    // single packet from req0
    do_reset();
    q0.push_back({1'b0, 8'h41});
    q0.push_back({1'b0, 8'h42});
    q0.push_back({1'b1, 8'h0A});
    drive();
    #1;
    chk("arb_ready", req_ready_o, 2'b00);
    chk("arb_grant", grant_o, 2'b00);
    tick();
    chk("p1_grant", grant_o, 2'b01);
    chk("p1_ready", req_ready_o, 2'b01);
    tick();
    chk("p1_b0_v", tx_valid_o, 1);
    chk("p1_b0", tx_data_o, 8'h41);
    tick();
    chk("p1_b1", tx_data_o, 8'h42);
    tick();
    chk("p1_b2", tx_data_o, 8'h0A);
    chk("p1_idle_grant", grant_o, 2'b00);
    chk("p1_busy_drain", busy_o, 1);
    tick();
    chk("p1_drained", tx_valid_o, 0);
    chk("p1_busy_end", busy_o, 0);
    chk("p1_rx_n", rx.size(), 3);
    chk_rx("p1_rx0", 0, 8'h41);
    chk_rx("p1_rx1", 1, 8'h42);
    chk_rx("p1_rx2", 2, 8'h0A);

    // contention from reset: req0 first, no interleave
    do_reset();
    q0.push_back({1'b0, 8'hA1});
    q0.push_back({1'b0, 8'hA2});
    q0.push_back({1'b1, 8'hA3});
    q1.push_back({1'b0, 8'hB1});
    q1.push_back({1'b0, 8'hB2});
    q1.push_back({1'b1, 8'hB3});
    drive();
    wait_rx(6, 40);
    for (int i = 0; i < 6; i++) chk_rx("c1_rx", i, e3a[i]);

    // after a req0 packet rr_ptr=1: req1 wins the tie
    rx.delete();
    q0.push_back({1'b1, 8'hE1});
    drive();
    wait_rx(1, 20);
    q0.push_back({1'b0, 8'hC1});
    q0.push_back({1'b0, 8'hC2});
    q0.push_back({1'b1, 8'hC3});
    q1.push_back({1'b0, 8'hD1});
    q1.push_back({1'b0, 8'hD2});
    q1.push_back({1'b1, 8'hD3});
    drive();
    wait_rx(7, 40);
    for (int i = 0; i < 7; i++) chk_rx("c2_rx", i, e3b[i]);

    // backpressure mid-packet
    do_reset();
    q0.push_back({1'b0, 8'h61});
    q0.push_back({1'b0, 8'h62});
    q0.push_back({1'b1, 8'h63});
    drive();
    tick();
    tick();
    chk("bp_first", tx_data_o, 8'h61);
    tx_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_hold_data", tx_data_o, 8'h61);
      chk("bp_hold_ready", req_ready_o, 2'b00);
      chk("bp_hold_grant", grant_o, 2'b01);
    end
    tx_ready_i = 1'b1;
    wait_rx(3, 20);
    for (int i = 0; i < 3; i++) chk_rx("bp_rx", i, e4[i]);

    // owner stalls after one byte without last
    do_reset();
    q0.push_back({1'b0, 8'h55});
    q1.push_back({1'b0, 8'h71});
    q1.push_back({1'b0, 8'h72});
    q1.push_back({1'b1, 8'h73});
    drive();
    tick();
    tick();
    chk("to_byte", tx_data_o, 8'h55);
    chk("to_grant0", grant_o, 2'b01);
`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_locked", grant_o, 2'b01);
    end
    tick();
    chk("to_revoked", grant_o, 2'b00);
    tick();
    chk("to_regrant", grant_o, 2'b10);
    wait_rx(4, 20);
    for (int i = 0; i < 4; i++) chk_rx("to_rx", i, e5[i]);
`else
    for (int i = 0; i < 1000; i++) begin
      tick();
      chk("nt_grant", grant_o, 2'b01);
      chk("nt_ready1", req_ready_o[1], 0);
    end
    chk("nt_rx_n", rx.size(), 1);
    chk_rx("nt_rx0", 0, 8'h55);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
